// File: rtl/mips_mem_master.sv
// CPU-side bus initiator: arbitrates data (priority) and fetch requests, one word transfer at a time.
// Latency: strobe one cycle after accept, done one cycle after the non-stalled strobe edge; waitrequest stretches BUS.
module mips_mem_master #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_done,
    output logic [31:0] fetch_instr,
    output logic        fetch_err,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [1:0]  data_size,
    input  logic        data_signed,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic        data_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state;
    logic        cur_data;
    logic        cur_we;
    logic        cur_signed;
    logic [1:0]  cur_size;
    logic [1:0]  cur_lo;

    // Request selection in IDLE: data wins, a fetch behaves as an aligned word read.
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_we;
    logic        sel_mis;
    logic [3:0]  sel_be;
    logic [31:0] sel_wd;

    always_comb begin
        sel_addr = data_req ? data_addr : fetch_addr;
        sel_size = data_req ? data_size : 2'b10;
        sel_we   = data_req & data_we;
        sel_mis  = 1'b0;
        sel_be   = 4'b1111;
        sel_wd   = data_wdata;
        case (sel_size)
            2'b00: begin
                sel_be = 4'b0001 << sel_addr[1:0];
                sel_wd = {4{data_wdata[7:0]}};
            end
            2'b01: begin
                sel_mis = sel_addr[0];
                sel_be  = sel_addr[1] ? 4'b1100 : 4'b0011;
                sel_wd  = {2{data_wdata[15:0]}};
            end
            default: sel_mis = |sel_addr[1:0];
        endcase
    end

    // Load lane extraction and extension from the live bus data.
    logic [31:0] rd_byte_sh;
    logic [31:0] rd_half_sh;
    logic [31:0] load_val;

    always_comb begin
        rd_byte_sh = readdata >> {cur_lo, 3'b000};
        rd_half_sh = readdata >> {cur_lo[1], 4'b0000};
        case (cur_size)
            2'b00:   load_val = {{24{cur_signed & rd_byte_sh[7]}}, rd_byte_sh[7:0]};
            2'b01:   load_val = {{16{cur_signed & rd_half_sh[15]}}, rd_half_sh[15:0]};
            default: load_val = readdata;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^RESET_VECTOR;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            read        <= 1'b0;
            write       <= 1'b0;
            address     <= '0;
            byteenable  <= '0;
            writedata   <= '0;
            fetch_done  <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_instr <= '0;
            data_done   <= 1'b0;
            data_err    <= 1'b0;
            data_rdata  <= '0;
            cur_data    <= 1'b0;
            cur_we      <= 1'b0;
            cur_signed  <= 1'b0;
            cur_size    <= '0;
            cur_lo      <= '0;
        end else begin
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            data_done  <= 1'b0;
            data_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_req || fetch_req) begin
                        cur_data   <= data_req;
                        cur_we     <= sel_we;
                        cur_signed <= data_signed;
                        cur_size   <= sel_size;
                        cur_lo     <= sel_addr[1:0];
                        if (sel_mis) begin
                            state <= RESP;
                            if (data_req) begin
                                data_done  <= 1'b1;
                                data_err   <= 1'b1;
                                data_rdata <= '0;
                            end else begin
                                fetch_done  <= 1'b1;
                                fetch_err   <= 1'b1;
                                fetch_instr <= '0;
                            end
                        end else begin
                            state      <= BUS;
                            read       <= ~sel_we;
                            write      <= sel_we;
                            address    <= {sel_addr[31:2], 2'b00};
                            byteenable <= sel_be;
                            writedata  <= sel_we ? sel_wd : '0;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        state <= RESP;
                        if (cur_data) begin
                            data_done <= 1'b1;
                            if (!cur_we) data_rdata <= load_val;
                        end else begin
                            fetch_done  <= 1'b1;
                            fetch_instr <= readdata;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_master.sv
// Directed plus randomized transactions against a lane/extension reference model of the bus initiator.
module tb_mips_mem_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, fetch_done, fetch_err;
    logic [31:0] fetch_addr, fetch_instr;
    logic        data_req, data_we, data_signed, data_done, data_err;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata = 0;
    logic [31:0] last_instr = 0;

    mips_mem_master dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
        .fetch_instr(fetch_instr), .fetch_err(fetch_err),
        .data_req(data_req), .data_we(data_we), .data_size(data_size),
        .data_signed(data_signed), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_done(data_done), .data_rdata(data_rdata), .data_err(data_err),
        .address(address), .read(read), .write(write), .byteenable(byteenable),
        .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) chk("read_write_exclusive", {31'b0, read & write}, 32'd0);
    end

    function automatic logic [31:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int lo = addr % 4;
        if (size == 0) return 32'(1 << lo);
        if (size == 1) return (lo >= 2) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wd);
        if (size == 0) return (wd % 256) * 32'h01010101;
        if (size == 1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic sgn,
                                           input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        int lo = addr % 4;
        if (size == 0) begin
            v = (rd >> (8 * lo)) % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = (rd >> (16 * (lo / 2))) % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end else v = rd;
        return v;
    endfunction

    task automatic data_txn(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int waits);
        logic mis;
        mis = (size == 1 && (addr % 2) != 0) || (size >= 2 && (addr % 4) != 0);
        data_req = 1; data_we = we; data_size = size; data_signed = sgn;
        data_addr = addr; data_wdata = wd; readdata = rd; waitrequest = (waits > 0);
        @(posedge clk); #1;
        if (mis) begin
            chk("mis_read", {31'b0, read}, 0);
            chk("mis_write", {31'b0, write}, 0);
            chk("mis_done", {31'b0, data_done}, 1);
            chk("mis_err", {31'b0, data_err}, 1);
            chk("mis_rdata", data_rdata, 0);
            last_rdata = 0;
        end else begin
            for (int w = 0; w <= waits; w++) begin
                chk("d_read", {31'b0, read}, {31'b0, ~we});
                chk("d_write", {31'b0, write}, {31'b0, we});
                chk("d_address", address, addr & 32'hFFFFFFFC);
                chk("d_byteenable", {28'b0, byteenable}, m_be(size, addr));
                if (we) chk("d_writedata", writedata, m_wd(size, wd));
                chk("d_done_early", {31'b0, data_done}, 0);
                if (w == waits) waitrequest = 0;
                @(posedge clk); #1;
            end
            chk("d_done", {31'b0, data_done}, 1);
            chk("d_err", {31'b0, data_err}, 0);
            chk("d_strobe_off", {30'b0, read, write}, 0);
            chk("d_no_fetch_done", {31'b0, fetch_done}, 0);
            if (!we) last_rdata = m_load(size, sgn, addr, rd);
            chk("d_rdata", data_rdata, last_rdata);
        end
        data_req = 0;
        @(posedge clk); #1;
        chk("d_done_pulse", {31'b0, data_done}, 0);
        chk("d_err_idle", {31'b0, data_err}, 0);
        chk("d_rdata_hold", data_rdata, last_rdata);
    endtask

    task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] rd, input int waits);
        logic mis;
        mis = (addr % 4) != 0;
        fetch_req = 1; fetch_addr = addr; readdata = rd; waitrequest = (waits > 0);
        @(posedge clk); #1;
        if (mis) begin
            chk("fmis_read", {31'b0, read}, 0);
            chk("fmis_done", {31'b0, fetch_done}, 1);
            chk("fmis_err", {31'b0, fetch_err}, 1);
            chk("fmis_instr", fetch_instr, 0);
            last_instr = 0;
        end else begin
            for (int w = 0; w <= waits; w++) begin
                chk("f_read", {31'b0, read}, 1);
                chk("f_write", {31'b0, write}, 0);
                chk("f_address", address, addr & 32'hFFFFFFFC);
                chk("f_byteenable", {28'b0, byteenable}, 32'd15);
                chk("f_done_early", {31'b0, fetch_done}, 0);
                if (w == waits) waitrequest = 0;
                @(posedge clk); #1;
            end
            chk("f_done", {31'b0, fetch_done}, 1);
            chk("f_err", {31'b0, fetch_err}, 0);
            chk("f_read_off", {31'b0, read}, 0);
            last_instr = rd;
            chk("f_instr", fetch_instr, last_instr);
        end
        fetch_req = 0;
        @(posedge clk); #1;
        chk("f_done_pulse", {31'b0, fetch_done}, 0);
        chk("f_err_idle", {31'b0, fetch_err}, 0);
        chk("f_instr_hold", fetch_instr, last_instr);
    endtask

    initial begin
        reset = 1; fetch_req = 0; fetch_addr = 0; data_req = 0; data_we = 0;
        data_size = 0; data_signed = 0; data_addr = 0; data_wdata = 0;
        waitrequest = 0; readdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", {30'b0, read, write}, 0);
        chk("rst_dones", {28'b0, fetch_done, data_done, fetch_err, data_err}, 0);
        chk("rst_address", address, 0);
        chk("rst_byteenable", {28'b0, byteenable}, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_instr", fetch_instr, 0);
        chk("rst_rdata", data_rdata, 0);
        reset = 0;
        @(posedge clk); #1;

        fetch_txn(32'hBFC00000, 32'h24020005, 0);
        chk("boot_instr_const", fetch_instr, 32'h24020005);
        data_txn(0, 2'b00, 1, 32'h3, 0, 32'h80112233, 0);
        chk("sbyte_const", data_rdata, 32'hFFFFFF80);
        data_txn(0, 2'b00, 0, 32'h3, 0, 32'h80112233, 0);
        chk("ubyte_const", data_rdata, 32'h00000080);
        data_txn(1, 2'b01, 0, 32'h6, 32'h1234ABCD, 0, 3);

        // Both requests at once: data is served first, fetch right after.
        fetch_req = 1; fetch_addr = 32'h100;
        data_txn(0, 2'b10, 0, 32'h10, 0, 32'hCAFEF00D, 1);
        chk("arb_fetch_pending_no_strobe", {31'b0, read}, 0);
        fetch_txn(32'h100, 32'h01234567, 0);

        data_txn(0, 2'b10, 0, 32'h2, 0, 32'hFFFFFFFF, 0);
        data_txn(0, 2'b01, 1, 32'h5, 0, 32'h12345678, 0);
        fetch_txn(32'h202, 32'h11111111, 0);

        // Reset in the middle of a stalled transfer.
        data_req = 1; data_we = 0; data_size = 2'b10; data_addr = 32'h20; waitrequest = 1;
        @(posedge clk); #1;
        chk("rb_read", {31'b0, read}, 1);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        chk("rb_read_cleared", {31'b0, read}, 0);
        chk("rb_no_done", {31'b0, data_done}, 0);
        chk("rb_address", address, 0);
        reset = 0; data_req = 0; waitrequest = 0;
        last_rdata = 0; last_instr = 0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rb_idle_read", {31'b0, read}, 0);
            chk("rb_idle_done", {31'b0, data_done}, 0);
        end
        data_txn(0, 2'b10, 0, 32'h20, 0, 32'h5A5AA5A5, 0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [1:0] sz;
            a = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFFFFFC | (sz == 0 ? a % 4 : (sz == 1 ? a % 4 & 2 : 0));
            if ($urandom_range(0, 3) == 0)
                fetch_txn(a, $urandom, $urandom_range(0, 3));
            else
                data_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                         $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
